// File: rtl/snoop_ac_queue.sv
// AC-channel snoop request queue: a small FIFO in front of the D-cache snoop controller.
// It holds the head on line collisions with AMO/writeback or while the cache is flushing, and flags starvation.
module snoop_ac_queue #(
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 64,
    parameter int SNOOP_WIDTH   = 4,
    parameter int LINE_OFFSET   = 4,
    parameter int STARVE_CYCLES = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ac_valid_i,
    output logic                     ac_ready_o,
    input  logic [ADDR_WIDTH-1:0]    ac_addr_i,
    input  logic [SNOOP_WIDTH-1:0]   ac_snoop_i,
    output logic                     ac_valid_o,
    input  logic                     ac_ready_i,
    output logic [ADDR_WIDTH-1:0]    ac_addr_o,
    output logic [SNOOP_WIDTH-1:0]   ac_snoop_o,
    input  logic                     flushing_i,
    input  logic                     amo_valid_i,
    input  logic [ADDR_WIDTH-1:0]    amo_addr_i,
    input  logic                     wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]    wb_addr_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     starve_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STV_W  = $clog2(STARVE_CYCLES + 1);
    localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET;

    logic [ADDR_WIDTH-1:0]  r_addrMem  [DEPTH];
    logic [SNOOP_WIDTH-1:0] r_snoopMem [DEPTH];
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_presented;
    logic [STV_W-1:0]       r_starveCnt;
    logic                   r_starve;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_hold;
    logic                   w_valid;
    logic                   w_amoHit;
    logic                   w_wbHit;
    logic [LINE_W-1:0]      w_headLine;
    logic [ADDR_WIDTH-1:0]  w_headAddr;
    logic [SNOOP_WIDTH-1:0] w_headSnoop;
    logic [STV_W-1:0]       w_starveNext;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_headAddr  = r_addrMem[r_rdPtr];
    assign w_headSnoop = r_snoopMem[r_rdPtr];
    assign w_headLine  = w_headAddr[ADDR_WIDTH-1:LINE_OFFSET];

    assign w_amoHit = amo_valid_i && (amo_addr_i[ADDR_WIDTH-1:LINE_OFFSET] == w_headLine);
    assign w_wbHit  = wb_valid_i  && (wb_addr_i[ADDR_WIDTH-1:LINE_OFFSET]  == w_headLine);
    assign w_hold   = flushing_i || w_amoHit || w_wbHit;

    // Once shown, valid must stay up until the handshake even if a hold appears later.
    assign w_valid = !w_empty && (r_presented || !w_hold);

    assign w_push = ac_valid_i && !w_full;
    assign w_pop  = w_valid && ac_ready_i;

    assign ac_ready_o = !w_full;
    assign ac_valid_o = w_valid;
    assign ac_addr_o  = w_empty ? '0 : w_headAddr;
    assign ac_snoop_o = w_empty ? '0 : w_headSnoop;
    assign count_o    = r_count;
    assign starve_o   = r_starve;

    always_comb begin
        w_starveNext = r_starveCnt;
        if (w_empty || w_valid) begin
            w_starveNext = '0;
        end else if (r_starveCnt != STV_W'(STARVE_CYCLES)) begin
            w_starveNext = r_starveCnt + STV_W'(1);
        end
    end

    // Entry storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addrMem[r_wrPtr]  <= ac_addr_i;
            r_snoopMem[r_wrPtr] <= ac_snoop_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_presented <= 1'b0;
            r_starveCnt <= '0;
            r_starve    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_presented <= w_valid && !ac_ready_i;
            r_starveCnt <= w_starveNext;
            r_starve    <= (w_starveNext == STV_W'(STARVE_CYCLES));
        end
    end

endmodule
